// File: rtl/cache_access_arbiter.sv
// cache_access_arbiter
//   Shares one cacheSystem port between two requesters and provides a
//   two-cycle flush sequence. Both requesters are granted round-robin. Each
//   access is timed in BUSY cycles and is aborted if it runs too long.
//   Every output comes straight from a register.
//
// Ports
//   clock, reset                  : sole clock, synchronous active-high reset
//   req0/req1, addr0/addr1        : level requests and their (stable) addresses
//   flush_req                     : request a cacheSystem flush (beats reqN)
//   done0/done1                   : one-cycle completion pulse per requester
//   rdata, latency, timeout_err   : result of the last completed access (held)
//   flush_done                    : one-cycle pulse when a flush finishes
//   cache_reset/enable/addr       : drive the cacheSystem
//   cache_requestComplete/dataOut : cacheSystem response
module cache_access_arbiter #(
    parameter int ADDR_W  = 15,
    parameter int DATA_W  = 32,
    parameter int LAT_W   = 14,
    parameter int TIMEOUT = 10000
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req0,
    input  logic              req1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic              flush_req,
    output logic              done0,
    output logic              done1,
    output logic [DATA_W-1:0] rdata,
    output logic [LAT_W-1:0]  latency,
    output logic              timeout_err,
    output logic              flush_done,
    output logic              cache_reset,
    output logic              cache_enable,
    output logic [ADDR_W-1:0] cache_addr,
    input  logic              cache_requestComplete,
    input  logic [DATA_W-1:0] cache_dataOut
);

    localparam logic [LAT_W-1:0] LP_TIMEOUT = LAT_W'(TIMEOUT);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FLUSH_HI,
        S_FLUSH_LO,
        S_BUSY,
        S_RELEASE
    } state_t;

    // Latency counter increment that never climbs past the abort limit.
    function automatic logic [LAT_W-1:0] sat_inc(input logic [LAT_W-1:0] v);
        if (v >= LP_TIMEOUT) begin
            return LP_TIMEOUT;
        end
        return v + LAT_W'(1);
    endfunction

    state_t              r_state;
    logic [LAT_W-1:0]    r_cnt;
    logic                r_gnt;      // requester owning the current access
    logic                r_prio;     // requester that wins the next tie
    logic                r_cache_enable;
    logic                r_cache_reset;
    logic [ADDR_W-1:0]   r_cache_addr;
    logic [DATA_W-1:0]   r_rdata;
    logic [LAT_W-1:0]    r_latency;
    logic                r_timeout_err;
    logic                r_done0;
    logic                r_done1;
    logic                r_flush_done;

    state_t              w_state_nxt;
    logic [LAT_W-1:0]    w_cnt_nxt;
    logic [LAT_W-1:0]    w_cnt_inc;
    logic                w_gnt_nxt;
    logic                w_prio_nxt;
    logic                w_pick;
    logic                w_enable_nxt;
    logic                w_creset_nxt;
    logic [ADDR_W-1:0]   w_addr_nxt;
    logic [DATA_W-1:0]   w_rdata_nxt;
    logic [LAT_W-1:0]    w_lat_nxt;
    logic                w_terr_nxt;
    logic                w_done0_nxt;
    logic                w_done1_nxt;
    logic                w_fdone_nxt;

    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_gnt_nxt    = r_gnt;
        w_prio_nxt   = r_prio;
        w_enable_nxt = r_cache_enable;
        w_creset_nxt = 1'b0;
        w_addr_nxt   = r_cache_addr;
        w_rdata_nxt  = r_rdata;
        w_lat_nxt    = r_latency;
        w_terr_nxt   = r_timeout_err;
        w_done0_nxt  = 1'b0;
        w_done1_nxt  = 1'b0;
        w_fdone_nxt  = 1'b0;
        w_cnt_inc    = sat_inc(r_cnt);
        // Tie goes to the priority pointer; a lone request wins outright.
        w_pick       = (req0 && req1) ? r_prio : req1;

        unique case (r_state)
            S_IDLE: begin
                if (flush_req) begin
                    w_state_nxt  = S_FLUSH_HI;
                    w_creset_nxt = 1'b1;
                end else if (req0 || req1) begin
                    w_state_nxt  = S_BUSY;
                    w_gnt_nxt    = w_pick;
                    w_prio_nxt   = ~w_pick;
                    w_addr_nxt   = w_pick ? addr1 : addr0;
                    w_enable_nxt = 1'b1;
                    w_cnt_nxt    = '0;
                end
            end
            S_FLUSH_HI: begin
                w_state_nxt = S_FLUSH_LO;
            end
            S_FLUSH_LO: begin
                w_state_nxt = S_IDLE;
                w_fdone_nxt = 1'b1;
            end
            S_BUSY: begin
                if (cache_requestComplete) begin
                    w_state_nxt  = S_RELEASE;
                    w_enable_nxt = 1'b0;
                    w_rdata_nxt  = cache_dataOut;
                    w_lat_nxt    = r_cnt;
                    w_terr_nxt   = 1'b0;
                    w_done0_nxt  = ~r_gnt;
                    w_done1_nxt  = r_gnt;
                end else if (w_cnt_inc == LP_TIMEOUT) begin
                    // This incomplete cycle is the TIMEOUT-th one: abort.
                    w_state_nxt  = S_RELEASE;
                    w_cnt_nxt    = w_cnt_inc;
                    w_enable_nxt = 1'b0;
                    w_rdata_nxt  = '0;
                    w_lat_nxt    = LP_TIMEOUT;
                    w_terr_nxt   = 1'b1;
                    w_done0_nxt  = ~r_gnt;
                    w_done1_nxt  = r_gnt;
                end else begin
                    w_cnt_nxt = w_cnt_inc;
                end
            end
            S_RELEASE: begin
                w_state_nxt  = S_IDLE;
                w_enable_nxt = 1'b0;
            end
            default: begin
                w_state_nxt  = S_IDLE;
                w_enable_nxt = 1'b0;
            end
        endcase
    end

    // Registered state and outputs
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state        <= S_IDLE;
            r_cnt          <= '0;
            r_gnt          <= 1'b0;
            r_prio         <= 1'b0;
            r_cache_enable <= 1'b0;
            r_cache_reset  <= 1'b1;
            r_cache_addr   <= '0;
            r_rdata        <= '0;
            r_latency      <= '0;
            r_timeout_err  <= 1'b0;
            r_done0        <= 1'b0;
            r_done1        <= 1'b0;
            r_flush_done   <= 1'b0;
        end else begin
            r_state        <= w_state_nxt;
            r_cnt          <= w_cnt_nxt;
            r_gnt          <= w_gnt_nxt;
            r_prio         <= w_prio_nxt;
            r_cache_enable <= w_enable_nxt;
            r_cache_reset  <= w_creset_nxt;
            r_cache_addr   <= w_addr_nxt;
            r_rdata        <= w_rdata_nxt;
            r_latency      <= w_lat_nxt;
            r_timeout_err  <= w_terr_nxt;
            r_done0        <= w_done0_nxt;
            r_done1        <= w_done1_nxt;
            r_flush_done   <= w_fdone_nxt;
        end
    end

    assign done0        = r_done0;
    assign done1        = r_done1;
    assign rdata        = r_rdata;
    assign latency      = r_latency;
    assign timeout_err  = r_timeout_err;
    assign flush_done   = r_flush_done;
    assign cache_reset  = r_cache_reset;
    assign cache_enable = r_cache_enable;
    assign cache_addr   = r_cache_addr;

endmodule

// File: doc/cache_access_arbiter.md
CACHE_ACCESS_ARBITER -- requirements
Module: cache_access_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 15, cache address width.
REQ-002 SHALL have parameter DATA_W, default 32, cache data width.
REQ-003 SHALL have parameter LAT_W, default 14, latency counter width.
REQ-004 SHALL have parameter TIMEOUT, default 10000, BUSY-cycle limit before abort; TIMEOUT < 2^LAT_W.
REQ-005 SHALL have port clock, input, 1, sole clock; all state changes on rising edge.
REQ-006 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-007 SHALL have ports req0/req1, input, 1 each, level access request per requester.
REQ-008 SHALL have ports addr0/addr1, input, ADDR_W each, request address, held stable while reqN high.
REQ-009 SHALL have port flush_req, input, 1, request to empty the cache system.
REQ-010 SHALL have ports done0/done1, output, 1 each, one-cycle completion pulse.
REQ-011 SHALL have port rdata, output, DATA_W, data of last completed access.
REQ-012 SHALL have port latency, output, LAT_W, BUSY cycles of last completed access.
REQ-013 SHALL have port timeout_err, output, 1, qualifies done pulse as aborted.
REQ-014 SHALL have port flush_done, output, 1, one-cycle pulse when flush finishes.
REQ-015 SHALL have ports cache_reset, cache_enable, output, 1 each; cache_addr, output, ADDR_W: drive cacheSystem reset/enable/addr.
REQ-016 SHALL have ports cache_requestComplete, input, 1; cache_dataOut, input, DATA_W: from cacheSystem.

Function
REQ-017 SHALL implement states IDLE, FLUSH_HI, FLUSH_LO, BUSY, RELEASE; all outputs registered.
REQ-018 In IDLE with flush_req=1 SHALL enter FLUSH_HI; flush has priority over req0/req1.
REQ-019 FLUSH_HI SHALL drive cache_reset=1 one cycle; FLUSH_LO SHALL drive cache_reset=0 one cycle, pulse flush_done on exit, return to IDLE.
REQ-020 In IDLE with no flush and any reqN=1 SHALL grant one requester, latch addrN to cache_addr, set cache_enable=1, clear latency counter, enter BUSY.
REQ-021 Arbitration SHALL be round-robin: with both requests pending, grant the requester not granted last; after reset req0 wins the first tie.
REQ-022 In BUSY, each cycle with cache_requestComplete=0 SHALL increment latency counter by 1 (saturating at TIMEOUT).
REQ-023 In BUSY with cache_requestComplete=1 SHALL capture cache_dataOut to rdata, counter to latency, timeout_err=0, drop cache_enable, pulse doneN of granted requester next cycle, enter RELEASE.
REQ-024 In BUSY when counter reaches TIMEOUT with cache_requestComplete=0 SHALL drop cache_enable, set rdata=0, latency=TIMEOUT, timeout_err=1, pulse doneN, enter RELEASE.
REQ-025 RELEASE SHALL hold cache_enable=0 exactly one cycle then enter IDLE; no new grant before IDLE.
REQ-026 Minimum spacing between consecutive cache_enable rising edges SHALL be 3 cycles.
REQ-027 A reqN still high in IDLE after its done SHALL be treated as a new request; requesters drop reqN on doneN to avoid reissue.
REQ-028 cache_addr SHALL remain constant for whole BUSY interval regardless of addrN changes.
REQ-029 rdata, latency, timeout_err SHALL hold until next completion.
REQ-030 done0 and done1 SHALL never be high together; flush_done never coincides with doneN.
REQ-031 flush_req arriving during BUSY SHALL wait until IDLE, then win over pending reqN.

Reset
REQ-032 On reset=1 SHALL enter IDLE, cache_enable=0, cache_addr=0, cache_reset=1, done0/done1/flush_done=0, rdata=0, latency=0, timeout_err=0, round-robin pointer favouring req0.
REQ-033 Reset mid-BUSY or mid-FLUSH SHALL abort without done/flush_done pulse; requester must re-request.
REQ-034 First cycle after reset deasserts SHALL drive cache_reset=0.

Verification
REQ-035 Reset, req0=1 addr0=0, cache model completes after 7 BUSY cycles, data 0xDEADBEEF -> done0 pulse, rdata=0xDEADBEEF, latency=7, timeout_err=0.
REQ-036 req0 and req1 raised same cycle, both held through completion -> grants req0, req1, req0 order; done pulses alternate, never overlap.
REQ-037 Cache model never asserts requestComplete, req1=1 -> after 10000 BUSY cycles done1 pulse, timeout_err=1, latency=10000, rdata=0, cache_enable low next cycle.
REQ-038 flush_req and req0 same cycle in IDLE -> cache_reset high exactly 1 cycle, flush_done pulse, then req0 granted.
REQ-039 Reset asserted on 3rd BUSY cycle -> cache_enable=0 next cycle, no done0, state IDLE; subsequent req0 completes normally with latency counted from 0.
REQ-040 addr1 changed mid-BUSY from 0x0040 to 0x7FFF -> cache_addr stays 0x0040 until RELEASE.
